// File: rtl/sec7_pkg.sv
// ---------------------------------------------------------------------------
// sec7_pkg
//   Shared definitions for the seven-segment scan capture block:
//     - digit count and per-digit value width
//     - the eight legal 7-bit segment codes (bit 6 = a ... bit 0 = g)
//     - FSM state type for the capture sequencer
//     - is_onehot() helper used to qualify the digit strobe
// ---------------------------------------------------------------------------
package sec7_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned VAL_W      = 3;

    // Segment patterns, active-high, ordering a b c d e f g
    localparam logic [6:0] SEG_CODE_0 = 7'b1111110;
    localparam logic [6:0] SEG_CODE_1 = 7'b0110000;
    localparam logic [6:0] SEG_CODE_2 = 7'b1101101;
    localparam logic [6:0] SEG_CODE_3 = 7'b1111001;
    localparam logic [6:0] SEG_CODE_4 = 7'b0110011;
    localparam logic [6:0] SEG_CODE_5 = 7'b1011011;
    localparam logic [6:0] SEG_CODE_6 = 7'b1011111;
    localparam logic [6:0] SEG_CODE_7 = 7'b1110000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } scan_state_t;

    // True when exactly one strobe line is active
    function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            n += 32'(v[i]);
        end
        return (n == 1);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
//   Purely combinational pattern decoder for one digit.
//   Ports:
//     seg   in  7  segment pattern, bit 6 = a ... bit 0 = g
//     value out 3  decoded digit value (0 when the pattern is not legal)
//     err   out 1  pattern is not one of the eight legal codes
// ---------------------------------------------------------------------------
module seg7_decode
    import sec7_pkg::*;
(
    input  logic [6:0]       seg,
    output logic [VAL_W-1:0] value,
    output logic             err
);

    always_comb begin
        value = '0;
        err   = 1'b0;
        case (seg)
            SEG_CODE_0: value = 3'd0;
            SEG_CODE_1: value = 3'd1;
            SEG_CODE_2: value = 3'd2;
            SEG_CODE_3: value = 3'd3;
            SEG_CODE_4: value = 3'd4;
            SEG_CODE_5: value = 3'd5;
            SEG_CODE_6: value = 3'd6;
            SEG_CODE_7: value = 3'd7;
            default:    err   = 1'b1;
        endcase
    end

endmodule

// File: rtl/sec7tobi_scan.sv
// ---------------------------------------------------------------------------
// sec7tobi_scan
//   Recovers a 4-digit value from a multiplexed seven-segment display bus.
//   Each digit is captured once its {strobe, pattern} has been stable for
//   STABLE_CYC cycles; when all four digits have been seen the frame is
//   published on dig_val/dig_err with a one-cycle frame_valid pulse.
//   Parameters:
//     STABLE_CYC   cycles a sample must hold before capture (legal 2..15)
//   Ports:
//     clk          in   1   rising-edge clock
//     rst          in   1   synchronous active-high reset
//     seg_in       in   7   segment lines, bit 6 = a ... bit 0 = g
//     an_in        in   4   digit strobe, one-hot when valid
//     dig_val      out  12  captured frame, digit n at [3n+2:3n]
//     dig_err      out  4   per-digit illegal-pattern flag
//     frame_valid  out  1   one-cycle pulse when dig_val/dig_err update
//     busy         out  1   a partial frame is being assembled
// ---------------------------------------------------------------------------
module sec7tobi_scan
    import sec7_pkg::*;
#(
    parameter int unsigned STABLE_CYC = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [6:0]                  seg_in,
    input  logic [NUM_DIGITS-1:0]       an_in,
    output logic [NUM_DIGITS*VAL_W-1:0] dig_val,
    output logic [NUM_DIGITS-1:0]       dig_err,
    output logic                        frame_valid,
    output logic                        busy
);

    // Counter value that, held for one more unchanged edge, reaches STABLE_CYC
    localparam logic [3:0] CAP_CNT = 4'(STABLE_CYC - 1);

    // Sample register and its fields
    logic [NUM_DIGITS+6:0]       samp;
    logic [NUM_DIGITS-1:0]       samp_an;
    logic [6:0]                  samp_seg;

    logic [3:0]                  cnt;
    scan_state_t                 state;

    // Frame under assembly
    logic [NUM_DIGITS*VAL_W-1:0] stage_val;
    logic [NUM_DIGITS-1:0]       stage_err;
    logic [NUM_DIGITS-1:0]       seen;
    logic                        load_pend;

    // Combinational helpers
    logic                        chg;
    logic                        in_onehot;
    logic                        capture;
    logic [NUM_DIGITS-1:0]       seen_set;
    logic [VAL_W-1:0]            dec_val;
    logic                        dec_err;

    assign samp_an  = samp[NUM_DIGITS+6:7];
    assign samp_seg = samp[6:0];

    seg7_decode u_decode (
        .seg   (samp_seg),
        .value (dec_val),
        .err   (dec_err)
    );

    always_comb begin
        chg       = ({an_in, seg_in} != samp);
        in_onehot = is_onehot(an_in);
        // SETTLE is only entered with a one-hot strobe, so samp_an selects
        // exactly one slot whenever capture is asserted.
        capture   = (state == SETTLE) && !chg && (cnt == CAP_CNT);
        // A frame load clears seen first; a capture on the same edge then
        // lands in the fresh frame.
        seen_set  = (load_pend ? '0 : seen) | (capture ? samp_an : '0);
        busy      = (seen != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            samp        <= '0;
            cnt         <= '0;
            state       <= IDLE;
            stage_val   <= '0;
            stage_err   <= '0;
            seen        <= '0;
            load_pend   <= 1'b0;
            dig_val     <= '0;
            dig_err     <= '0;
            frame_valid <= 1'b0;
        end else begin
            samp <= {an_in, seg_in};

            if (chg) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 4'd1;
            end

            case (state)
                IDLE: begin
                    if (chg && in_onehot) begin
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (chg) begin
                        state <= in_onehot ? SETTLE : IDLE;
                    end else if (capture) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (chg) begin
                        state <= in_onehot ? SETTLE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (capture && samp_an[i]) begin
                    stage_val[VAL_W*i +: VAL_W] <= dec_val;
                    stage_err[i]                <= dec_err;
                end
            end

            seen        <= seen_set;
            load_pend   <= capture && (seen_set == '1);
            frame_valid <= load_pend;

            // Staging is read before this edge's capture write takes effect
            if (load_pend) begin
                dig_val <= stage_val;
                dig_err <= stage_err;
            end
        end
    end

endmodule

// File: tb/tb_sec7tobi_scan.sv
// ---------------------------------------------------------------------------
// tb_sec7tobi_scan
//   Self-checking bench for sec7tobi_scan: a directed table of held digit
//   patterns with expected frame results, hand-written multi-cycle
//   sequences, and randomized traffic compared every cycle against a
//   run-length based reference model.
// ---------------------------------------------------------------------------
module tb_sec7tobi_scan;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic [11:0] dig_val;
    logic [3:0]  dig_err;
    logic        frame_valid;
    logic        busy;

    sec7tobi_scan #(.STABLE_CYC(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .dig_val     (dig_val),
        .dig_err     (dig_err),
        .frame_valid (frame_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int fv_count;

    logic [6:0] codes [8];

    // Reference model state: a run is a stretch of edges with identical
    // {an,seg}; a run with a one-hot strobe captures on its S-th repeat.
    logic [10:0] m_prev = '0;
    int          m_run = 0;
    int          m_stage_val [4];
    bit          m_stage_err [4];
    bit          m_seen [4];
    bit          m_pend = 1'b0;
    int          m_out_val [4];
    bit          m_out_err [4];
    bit          m_fv = 1'b0;

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        int          hold;
        int          exp_fv;
        bit          exp_busy;
        logic [11:0] exp_val;
        logic [3:0]  exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    function automatic bit onehot(input logic [3:0] a);
        return (a != 4'd0) && ((a & (a - 4'd1)) == 4'd0);
    endfunction

    function automatic void ref_decode(input logic [6:0] p, output int v, output bit e);
        v = 0;
        e = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (codes[i] == p) begin
                v = i;
                e = 1'b0;
            end
        end
    endfunction

    function automatic logic [11:0] m_val_packed();
        logic [11:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[3*i +: 3] = 3'(m_out_val[i]);
        return r;
    endfunction

    function automatic logic [3:0] m_err_packed();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = m_out_err[i];
        return r;
    endfunction

    function automatic bit m_busy();
        bit b;
        b = 1'b0;
        for (int i = 0; i < 4; i++) b |= m_seen[i];
        return b;
    endfunction

    task automatic model_edge();
        logic [10:0] cur;
        bit all_seen;
        cur = {an_in, seg_in};
        if (rst) begin
            m_prev = '0;
            m_run  = 0;
            m_pend = 1'b0;
            m_fv   = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_stage_val[i] = 0; m_stage_err[i] = 1'b0; m_seen[i] = 1'b0;
                m_out_val[i] = 0;   m_out_err[i] = 1'b0;
            end
            return;
        end
        if (cur != m_prev) m_run = 0;
        else if (m_run < 1000) m_run++;
        m_prev = cur;
        m_fv   = m_pend;
        if (m_pend) begin
            for (int i = 0; i < 4; i++) begin
                m_out_val[i] = m_stage_val[i];
                m_out_err[i] = m_stage_err[i];
                m_seen[i]    = 1'b0;
            end
            m_pend = 1'b0;
        end
        if (m_run == S && onehot(cur[10:7])) begin
            int d; int v; bit e;
            d = 0;
            for (int i = 0; i < 4; i++) if (cur[7+i]) d = i;
            ref_decode(cur[6:0], v, e);
            m_stage_val[d] = v;
            m_stage_err[d] = e;
            m_seen[d]      = 1'b1;
            all_seen = 1'b1;
            for (int i = 0; i < 4; i++) all_seen &= m_seen[i];
            m_pend = all_seen;
        end
    endtask

    // One clock: advance the model with the inputs the DUT is about to
    // sample, then compare all outputs just after the edge.
    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        check("frame_valid", 32'(frame_valid), 32'(m_fv));
        check("dig_val", 32'(dig_val), 32'(m_val_packed()));
        check("dig_err", 32'(dig_err), 32'(m_err_packed()));
        check("busy", 32'(busy), 32'(m_busy()));
        if (frame_valid) fv_count++;
    endtask

    task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
        an_in  = an;
        seg_in = seg;
        repeat (n) cyc();
    endtask

    task automatic add(input logic [3:0] an, input logic [6:0] seg, input int hold_n,
                       input int fv, input bit bsy, input logic [11:0] val, input logic [3:0] err);
        vec_t v;
        v.an = an; v.seg = seg; v.hold = hold_n; v.exp_fv = fv;
        v.exp_busy = bsy; v.exp_val = val; v.exp_err = err;
        vecs.push_back(v);
    endtask

    initial begin
        codes[0] = 7'b1111110; codes[1] = 7'b0110000; codes[2] = 7'b1101101; codes[3] = 7'b1111001;
        codes[4] = 7'b0110011; codes[5] = 7'b1011011; codes[6] = 7'b1011111; codes[7] = 7'b1110000;

        // Full scan with codes 3,5,7,0
        add(4'b0001, 7'b1111001, 8, 0, 1, 12'h000, 4'h0);
        add(4'b0010, 7'b1011011, 8, 0, 1, 12'h000, 4'h0);
        add(4'b0100, 7'b1110000, 8, 0, 1, 12'h000, 4'h0);
        add(4'b1000, 7'b1111110, 8, 1, 0, 12'h1EB, 4'h0);
        // Illegal pattern on digit 2
        add(4'b0001, 7'b0110000, 8, 0, 1, 12'h1EB, 4'h0);
        add(4'b0010, 7'b1101101, 8, 0, 1, 12'h1EB, 4'h0);
        add(4'b0100, 7'b1010101, 8, 0, 1, 12'h1EB, 4'h0);
        add(4'b1000, 7'b0110011, 8, 1, 0, 12'h811, 4'b0100);
        // Digit 1 captured as 2, recaptured as 6
        add(4'b0010, 7'b1101101, 8, 0, 1, 12'h811, 4'b0100);
        add(4'b0001, 7'b1111110, 8, 0, 1, 12'h811, 4'b0100);
        add(4'b0010, 7'b1011111, 8, 0, 1, 12'h811, 4'b0100);
        add(4'b0100, 7'b1110000, 8, 0, 1, 12'h811, 4'b0100);
        add(4'b1000, 7'b1111001, 8, 1, 0, 12'h7F0, 4'h0);
        // Too-short hold on digit 0
        add(4'b0000, 7'b0000000, 4, 0, 0, 12'h7F0, 4'h0);
        add(4'b0001, 7'b1011011, S-1, 0, 0, 12'h7F0, 4'h0);
        add(4'b0000, 7'b0000000, 6, 0, 0, 12'h7F0, 4'h0);
        // Non-one-hot strobe leaves seen untouched
        add(4'b0001, 7'b0110000, 8, 0, 1, 12'h7F0, 4'h0);
        add(4'b0011, 7'b0110000, 20, 0, 1, 12'h7F0, 4'h0);
        add(4'b0010, 7'b1101101, 8, 0, 1, 12'h7F0, 4'h0);
        add(4'b0100, 7'b1111001, 8, 0, 1, 12'h7F0, 4'h0);
        add(4'b1000, 7'b0110011, 8, 1, 0, 12'h8D1, 4'h0);

        rst = 1'b1; an_in = '0; seg_in = '0;
        repeat (2) cyc();
        rst = 1'b0;
        check("rst_dig_val", 32'(dig_val), 32'h0);
        check("rst_dig_err", 32'(dig_err), 32'h0);
        check("rst_fv", 32'(frame_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        foreach (vecs[k]) begin
            fv_count = 0;
            hold(vecs[k].an, vecs[k].seg, vecs[k].hold);
            check($sformatf("vec%0d_fv", k), 32'(fv_count), 32'(vecs[k].exp_fv));
            check($sformatf("vec%0d_busy", k), 32'(busy), 32'(vecs[k].exp_busy));
            check($sformatf("vec%0d_val", k), 32'(dig_val), 32'(vecs[k].exp_val));
            check($sformatf("vec%0d_err", k), 32'(dig_err), 32'(vecs[k].exp_err));
        end

        // Glitch during settling restarts the stability count
        hold(4'b0001, 7'b1111001, 3);
        hold(4'b0001, 7'b1011011, 1);
        hold(4'b0001, 7'b1111001, 3);
        check("glitch_no_capture", 32'(busy), 32'h0);
        hold(4'b0001, 7'b1111001, 2);
        check("glitch_then_capture", 32'(busy), 32'h1);

        // Partial frame discarded by reset
        hold(4'b0010, 7'b0110000, 8);
        hold(4'b0100, 7'b1101101, 8);
        an_in = '0; seg_in = '0; rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_val", 32'(dig_val), 32'h0);
        fv_count = 0;
        hold(4'b0001, 7'b0110011, 8);
        hold(4'b0010, 7'b1011011, 8);
        hold(4'b0100, 7'b1011111, 8);
        hold(4'b1000, 7'b1110000, 8);
        check("postrst_fv_count", 32'(fv_count), 32'h1);
        check("postrst_val", 32'(dig_val), 32'hFAC);
        check("postrst_err", 32'(dig_err), 32'h0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            int r;
            logic [3:0] a;
            logic [6:0] s;
            r = $urandom_range(0, 9);
            if (r <= 6)      a = 4'b0001 << $urandom_range(0, 3);
            else if (r == 7) a = 4'b0000;
            else if (r == 8) a = 4'($urandom);
            else             a = an_in;
            if ($urandom_range(0, 1) == 0) s = codes[$urandom_range(0, 7)];
            else                           s = 7'($urandom);
            if ($urandom_range(0, 59) == 0) begin
                rst = 1'b1;
                cyc();
                rst = 1'b0;
            end
            hold(a, s, $urandom_range(1, 9));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
